axi_mem_slave: RTL and testbench
================================

Name: axi_mem_slave

Overview:
- AXI4 subordinate (responder) backed by single-port on-chip word memory.
- Serves the exec stage's load/store AXI master (LB/LW/LF, SB/SW/SF); sits between the core and BRAM at top level.
- Independent read and write channel FSMs share one memory port.
- Supports INCR/FIXED bursts, byte and word sizes, and SLVERR for out-of-range addresses.

Parameters:
- ADDR_W, 22, byte address width.
- DEPTH_WORDS, 65536, 32-bit words implemented; word index = addr[ADDR_W-1:2].
- ID_W, 4, transaction ID width.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- awid  in  ID_W  write ID
- awaddr  in  ADDR_W  write byte address
- awlen  in  8  beats-1
- awsize  in  3  beat size
- awburst  in  2  burst type
- awvalid  in  1  AW valid
- awready  out  1  AW ready
- wdata  in  32  write data
- wstrb  in  64  byte strobes; only [3:0] used
- wlast  in  1  last beat (ignored)
- wvalid  in  1  W valid
- wready  out  1  W ready
- bid  out  ID_W  response ID
- bresp  out  2  write response
- bvalid  out  1  B valid
- bready  in  1  B ready
- arid  in  ID_W  read ID
- araddr  in  ADDR_W  read byte address
- arlen  in  8  beats-1
- arsize  in  3  beat size
- arburst  in  2  burst type
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- rid  out  ID_W  read ID
- rdata  out  32  read data
- rresp  out  2  read response
- rlast  out  1  last read beat
- rvalid  out  1  R valid
- rready  in  1  R ready

Behaviour:
- Reset (rstn=0 at posedge): both FSMs go idle. awready=1, arready=1; wready, bvalid, rvalid, rlast=0; bresp, rresp=00; bid, rid, rdata=0. Memory contents are not cleared. Reset mid-burst abandons the transaction with no response.
- Size: 000 = byte, 010 = word; any other value is treated as 010. Beat address increment is 1 (byte) or 4 (word); FIXED (00) does not increment; WRAP (10) is treated as INCR. Address arithmetic is mod 2^ADDR_W.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. AW handshake latches id, addr, len, size, burst; clears beat count and error flag; next state W_DATA.
  - W_DATA: awready=0, wready=1. Each W handshake writes the memory the same edge.
    - Word size: byte lanes per wstrb[3:0]; addr[1:0] ignored.
    - Byte size: wdata[7:0] goes to lane addr[1:0], gated by wstrb[0].
  - Beat counter is authoritative. After beat awlen, wready drops next cycle and state goes to W_RESP.
  - W_RESP: bvalid=1, bid=latched id. bresp=10 (SLVERR) if any beat had word index >= DEPTH_WORDS (such writes are dropped), else 00. On B handshake -> W_IDLE with awready=1 the next cycle.
- Read FSM, R_IDLE -> R_MEM -> R_DATA:
  - R_IDLE: arready=1. AR handshake latches fields; next state R_MEM.
  - R_MEM: issues a synchronous memory read unless a write beat uses the port this cycle. Write has priority; the read holds in R_MEM and retries.
  - R_DATA: rvalid=1, rdata held stable until R handshake.
    - Word size: full word.
    - Byte size: {24'h0, selected byte}.
    - Out of range: rdata=0, rresp=10; otherwise rresp=00.
  - rlast=1 on beat arlen. After a handshake on a non-last beat -> R_MEM with the next address; on the last beat -> R_IDLE.
- Latency:
  - AR handshake at edge T gives rvalid high from T+2; each further beat takes 2 cycles if rready is held.
  - AW at T gives wready at T+1; the single-beat W handshake at T+1 gives bvalid at T+2.
- Same-cycle write and read to the same word: the write commits first, and the read returns the new data.
- Read and write channels may be in flight simultaneously; there is no ordering between them other than the port priority above.

Decomposition:
- Package axi_mem_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - BURST_FIXED/INCR/WRAP
  - SIZE_BYTE=3'b000, SIZE_WORD=3'b010
  - write and read state enums
  - beat-address-increment function
- Sub-module mem_sp_bytewe: single-port DEPTH_WORDS x 32 RAM with 4-bit byte write enable and registered read (1 cycle), inferable as BRAM.

Test Plan:
- Word round trip: AW addr 0x000100, len 0, size 010, wdata 0xDEADBEEF, wstrb 0xF. Expect bvalid at T+2, bresp 00, bid=awid. Then AR 0x000100 gives rdata 0xDEADBEEF, rlast=1, rresp 00, rvalid at T+2.
- Byte ops: SB 0xAA to 0x000102 over 0x11223344. Expect word 0x11AA3344. LB 0x000102 returns 0x000000AA.
- INCR burst: write len 3 at 0x000200, data 1, 2, 3, 4. Read len 3 with rready toggled every other cycle. Expect 1, 2, 3, 4 stable while stalled, rlast only on beat 3.
- Out of range: with DEPTH_WORDS=1024, write 0x001000. Expect bresp 10 and memory unchanged. A read there gives rdata 0, rresp 10.
- Conflict: a write beat to 0x000300 (0x5) in the same cycle R_MEM reads 0x000300 (old 0x9). Expect the read delayed one cycle, returning 0x5.
- Backpressure/reset: hold bready=0 for 10 cycles; bvalid stays 1 and awready stays 0. Assert rstn=0 mid-read burst; after 1 cycle expect rvalid=0, arready=1, awready=1.

Source files
------------

// File: rtl/axi_mem_pkg.sv
// Shared constants, FSM state types and burst address helper for the AXI memory responder.
package axi_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [2:0] SIZE_BYTE = 3'b000;
    localparam logic [2:0] SIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_MEM  = 2'b01,
        R_DATA = 2'b10
    } r_state_t;

    // WRAP is deliberately handled like INCR; unknown sizes behave as word.
    function automatic logic [31:0] beat_incr(input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] inc;
        if (burst == BURST_FIXED) begin
            inc = 32'd0;
        end else if (size == SIZE_BYTE) begin
            inc = 32'd1;
        end else begin
            inc = 32'd4;
        end
        return inc;
    endfunction

endpackage

// File: rtl/mem_sp_bytewe.sv
// Single-port word RAM with per-byte write enables and a one-cycle registered read.
module mem_sp_bytewe #(
    parameter int unsigned DEPTH = 65536,
    parameter int unsigned AW    = 16
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Byte-lane writes; read data refreshes only on pure read cycles so it holds otherwise
    always_ff @(posedge clk) begin
        if (en) begin
            if (we != 4'b0000) begin
                for (int i = 0; i < 4; i++) begin
                    if (we[i]) begin
                        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 responder over a single-port word memory; independent read and write FSMs,
// write channel wins the shared port when both want it in the same cycle.
module axi_mem_slave #(
    parameter int          ADDR_W      = 22,
    parameter int unsigned DEPTH_WORDS = 65536,
    parameter int          ID_W        = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ID_W-1:0]   awid,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       wdata,
    input  logic [63:0]       wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ID_W-1:0]   arid,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [ID_W-1:0]   rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready
);
    import axi_mem_pkg::*;

    localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    w_state_t            w_state_r, w_state_nxt;
    logic [ID_W-1:0]     bid_r;
    logic [ADDR_W-1:0]   w_addr_r;
    logic [7:0]          w_len_r, w_cnt_r;
    logic [2:0]          w_size_r;
    logic [1:0]          w_burst_r, bresp_r;
    logic                w_err_r, awready_r, wready_r, bvalid_r;

    r_state_t            r_state_r, r_state_nxt;
    logic [ID_W-1:0]     rid_r;
    logic [ADDR_W-1:0]   r_addr_r;
    logic [7:0]          r_len_r, r_cnt_r;
    logic [2:0]          r_size_r;
    logic [1:0]          r_burst_r, rresp_r;
    logic                r_err_r, arready_r, rvalid_r, rlast_r;

    logic                aw_fire_s, w_fire_s, ar_fire_s, r_issue_s, r_fire_s;
    logic [ADDR_W-3:0]   w_idx_s, r_idx_s;
    logic                w_in_range_s, r_in_range_s;
    logic [31:0]         w_inc_s, r_inc_s;
    logic [3:0]          w_we_s;
    logic [31:0]         w_wdata_s, rdata_s;
    logic                mem_en_s;
    logic [3:0]          mem_we_s;
    logic [MEM_AW-1:0]   mem_addr_s;
    logic [31:0]         mem_rdata_s;
    logic                unused_s;

    assign aw_fire_s    = (w_state_r == W_IDLE) && awvalid;
    assign w_fire_s     = (w_state_r == W_DATA) && wvalid;
    assign ar_fire_s    = (r_state_r == R_IDLE) && arvalid;
    assign r_issue_s    = (r_state_r == R_MEM) && !w_fire_s;
    assign r_fire_s     = (r_state_r == R_DATA) && rready;
    assign w_idx_s      = w_addr_r[ADDR_W-1:2];
    assign r_idx_s      = r_addr_r[ADDR_W-1:2];
    assign w_in_range_s = (32'(w_idx_s) < DEPTH_WORDS);
    assign r_in_range_s = (32'(r_idx_s) < DEPTH_WORDS);
    assign w_inc_s      = beat_incr(w_size_r, w_burst_r);
    assign r_inc_s      = beat_incr(r_size_r, r_burst_r);
    assign unused_s     = ^{wstrb[63:4], wlast};

    // Write channel next state
    always_comb begin
        w_state_nxt = w_state_r;
        case (w_state_r)
            W_IDLE: if (awvalid) w_state_nxt = W_DATA; else w_state_nxt = W_IDLE;
            W_DATA: if (wvalid && (w_cnt_r == w_len_r)) w_state_nxt = W_RESP; else w_state_nxt = W_DATA;
            W_RESP: if (bready) w_state_nxt = W_IDLE; else w_state_nxt = W_RESP;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Write state, latched AW fields, beat counter and sticky range error
    always_ff @(posedge clk) begin
        if (!rstn) begin
            w_state_r <= W_IDLE;
            awready_r <= 1'b1;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
            bid_r     <= {ID_W{1'b0}};
            w_addr_r  <= {ADDR_W{1'b0}};
            w_len_r   <= 8'h00;
            w_cnt_r   <= 8'h00;
            w_size_r  <= SIZE_WORD;
            w_burst_r <= BURST_INCR;
            w_err_r   <= 1'b0;
        end else begin
            w_state_r <= w_state_nxt;
            awready_r <= (w_state_nxt == W_IDLE);
            wready_r  <= (w_state_nxt == W_DATA);
            bvalid_r  <= (w_state_nxt == W_RESP);
            bresp_r   <= ((w_state_nxt == W_RESP) && (w_err_r || (w_fire_s && !w_in_range_s)))
                         ? RESP_SLVERR : RESP_OKAY;
            if (aw_fire_s) begin
                bid_r     <= awid;
                w_addr_r  <= awaddr;
                w_len_r   <= awlen;
                w_size_r  <= awsize;
                w_burst_r <= awburst;
                w_cnt_r   <= 8'h00;
                w_err_r   <= 1'b0;
            end else if (w_fire_s) begin
                w_err_r <= w_err_r | !w_in_range_s;
                if (w_cnt_r != w_len_r) begin
                    w_cnt_r  <= w_cnt_r + 8'd1;
                    w_addr_r <= w_addr_r + w_inc_s[ADDR_W-1:0];
                end
            end
        end
    end

    // Byte beats replicate the low byte and enable only the addressed lane
    always_comb begin
        w_we_s    = 4'b0000;
        w_wdata_s = wdata;
        if (w_size_r == SIZE_BYTE) begin
            w_wdata_s = {4{wdata[7:0]}};
            if (wstrb[0]) w_we_s = 4'b0001 << w_addr_r[1:0]; else w_we_s = 4'b0000;
        end else begin
            w_we_s    = wstrb[3:0];
            w_wdata_s = wdata;
        end
    end

    // Shared port arbitration: a write beat pre-empts a pending read issue
    always_comb begin
        mem_en_s   = 1'b0;
        mem_we_s   = 4'b0000;
        mem_addr_s = r_idx_s[MEM_AW-1:0];
        if (w_fire_s) begin
            mem_en_s   = w_in_range_s && (w_we_s != 4'b0000);
            mem_we_s   = w_in_range_s ? w_we_s : 4'b0000;
            mem_addr_s = w_idx_s[MEM_AW-1:0];
        end else begin
            mem_en_s   = r_issue_s && r_in_range_s;
            mem_we_s   = 4'b0000;
            mem_addr_s = r_idx_s[MEM_AW-1:0];
        end
    end

    mem_sp_bytewe #(
        .DEPTH (DEPTH_WORDS),
        .AW    (MEM_AW)
    ) u_mem (
        .clk   (clk),
        .en    (mem_en_s),
        .we    (mem_we_s),
        .addr  (mem_addr_s),
        .wdata (w_wdata_s),
        .rdata (mem_rdata_s)
    );

    // Read channel next state
    always_comb begin
        r_state_nxt = r_state_r;
        case (r_state_r)
            R_IDLE: if (arvalid) r_state_nxt = R_MEM; else r_state_nxt = R_IDLE;
            R_MEM:  if (!w_fire_s) r_state_nxt = R_DATA; else r_state_nxt = R_MEM;
            R_DATA: begin
                if (rready) begin
                    if (r_cnt_r == r_len_r) r_state_nxt = R_IDLE; else r_state_nxt = R_MEM;
                end else begin
                    r_state_nxt = R_DATA;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Read state, latched AR fields and per-beat status
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b1;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rresp_r   <= RESP_OKAY;
            rid_r     <= {ID_W{1'b0}};
            r_addr_r  <= {ADDR_W{1'b0}};
            r_len_r   <= 8'h00;
            r_cnt_r   <= 8'h00;
            r_size_r  <= SIZE_WORD;
            r_burst_r <= BURST_INCR;
            r_err_r   <= 1'b0;
        end else begin
            r_state_r <= r_state_nxt;
            arready_r <= (r_state_nxt == R_IDLE);
            rvalid_r  <= (r_state_nxt == R_DATA);
            if (ar_fire_s) begin
                rid_r     <= arid;
                r_addr_r  <= araddr;
                r_len_r   <= arlen;
                r_size_r  <= arsize;
                r_burst_r <= arburst;
                r_cnt_r   <= 8'h00;
                r_err_r   <= 1'b0;
            end else if (r_issue_s) begin
                r_err_r <= !r_in_range_s;
                rlast_r <= (r_cnt_r == r_len_r);
                rresp_r <= r_in_range_s ? RESP_OKAY : RESP_SLVERR;
            end else if (r_fire_s) begin
                rlast_r <= 1'b0;
                rresp_r <= RESP_OKAY;
                r_err_r <= 1'b0;
                if (r_cnt_r != r_len_r) begin
                    r_cnt_r  <= r_cnt_r + 8'd1;
                    r_addr_r <= r_addr_r + r_inc_s[ADDR_W-1:0];
                end
            end
        end
    end

    // Read data comes straight off the RAM output register, which holds until the next issue
    always_comb begin
        rdata_s = 32'h0000_0000;
        if ((r_state_r == R_DATA) && !r_err_r) begin
            if (r_size_r == SIZE_BYTE) begin
                rdata_s = {24'h00_0000, mem_rdata_s[{r_addr_r[1:0], 3'b000} +: 8]};
            end else begin
                rdata_s = mem_rdata_s;
            end
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    assign awready = awready_r;
    assign wready  = wready_r;
    assign bvalid  = bvalid_r;
    assign bresp   = bresp_r;
    assign bid     = bid_r;
    assign arready = arready_r;
    assign rvalid  = rvalid_r;
    assign rlast   = rlast_r;
    assign rresp   = rresp_r;
    assign rid     = rid_r;
    assign rdata   = rdata_s;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed self-checking bench for axi_mem_slave (1024-word memory so range errors are reachable).
module tb_axi_mem_slave;

    localparam int          ADDR_W      = 22;
    localparam int          ID_W        = 4;
    localparam int unsigned DEPTH_WORDS = 1024;

    logic              clk;
    logic              rstn;
    logic [ID_W-1:0]   awid, arid, bid, rid;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [7:0]        awlen, arlen;
    logic [2:0]        awsize, arsize;
    logic [1:0]        awburst, arburst, bresp, rresp;
    logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rlast, rvalid, rready;
    logic [31:0]       wdata, rdata;
    logic [63:0]       wstrb;

    int total = 0;
    int bad   = 0;

    logic [31:0] wbuf    [8];
    logic [31:0] rdat_a  [8];
    logic [31:0] rdat_b  [8];
    logic        rlast_b [8];
    logic [1:0]  rresp_b [8];
    logic [3:0]  rid_o;

    axi_mem_slave #(
        .ADDR_W      (ADDR_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .ID_W        (ID_W)
    ) dut (
        .clk(clk), .rstn(rstn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [21:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [63:0] strb,
                             output logic ok, output logic [1:0] resp, output logic [3:0] rbid,
                             output int w_wait, output int b_wait);
        int n;
        ok = 1'b1;
        w_wait = 0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin step(); n++; end
        if (!awready) ok = 1'b0;
        step();
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wdata = wbuf[b]; wstrb = strb; wlast = (b == int'(len)); wvalid = 1'b1;
            n = 0;
            while (!wready && n < 50) begin step(); n++; end
            if (!wready) ok = 1'b0;
            if (b == 0) w_wait = n;
            step();
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        b_wait = 0;
        while (!bvalid && b_wait < 50) begin step(); b_wait++; end
        if (!bvalid) ok = 1'b0;
        resp = bresp;
        rbid = bid;
        step();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [21:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic stall,
                            output logic ok, output int first_wait);
        int n;
        ok = 1'b1;
        first_wait = 0;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin step(); n++; end
        if (!arready) ok = 1'b0;
        step();
        arvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            rready = 1'b0;
            n = 0;
            while (!rvalid && n < 50) begin step(); n++; end
            if (!rvalid) ok = 1'b0;
            if (b == 0) first_wait = n;
            rdat_a[b] = rdata;
            if (stall) begin
                step();
                if (!rvalid) ok = 1'b0;
            end
            rdat_b[b]  = rdata;
            rlast_b[b] = rlast;
            rresp_b[b] = rresp;
            rid_o      = rid;
            rready = 1'b1;
            step();
        end
        rready = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        step(); step();
        total++;
        if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b110000) begin
            bad++;
            $display("FAIL reset_handshake got=%b want=110000", {awready, arready, wready, bvalid, rvalid, rlast});
        end
        total++;
        if ({bresp, rresp, bid, rid, rdata} !== 44'h0) begin
            bad++;
            $display("FAIL reset_data got=%h want=0", {bresp, rresp, bid, rid, rdata});
        end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_word_round_trip;
        logic ok; logic [1:0] resp; logic [3:0] id_o; int ww, bw, fw;
        wbuf[0] = 32'hDEAD_BEEF;
        axi_write(4'h5, 22'h000100, 8'd0, 3'b010, 2'b01, 64'hF, ok, resp, id_o, ww, bw);
        total++;
        if (!ok || ww != 0 || bw != 0) begin
            bad++;
            $display("FAIL wr_latency got=ok%0d/w%0d/b%0d want=ok1/w0/b0", ok, ww, bw);
        end
        total++;
        if (resp !== 2'b00 || id_o !== 4'h5) begin
            bad++;
            $display("FAIL wr_bresp_bid got=%b/%h want=00/5", resp, id_o);
        end
        axi_read(4'h3, 22'h000100, 8'd0, 3'b010, 2'b01, 1'b0, ok, fw);
        total++;
        if (!ok || fw != 1) begin
            bad++;
            $display("FAIL rd_latency got=ok%0d/wait%0d want=ok1/wait1", ok, fw);
        end
        total++;
        if (rdat_a[0] !== 32'hDEAD_BEEF || rlast_b[0] !== 1'b1 || rresp_b[0] !== 2'b00 || rid_o !== 4'h3) begin
            bad++;
            $display("FAIL rd_word got=%h/%b/%b/%h want=deadbeef/1/00/3", rdat_a[0], rlast_b[0], rresp_b[0], rid_o);
        end
    endtask

    task automatic test_byte_ops;
        logic ok; logic [1:0] resp; logic [3:0] id_o; int ww, bw, fw;
        wbuf[0] = 32'h1122_3344;
        axi_write(4'h1, 22'h000100, 8'd0, 3'b010, 2'b01, 64'hF, ok, resp, id_o, ww, bw);
        wbuf[0] = 32'h0000_00AA;
        axi_write(4'h1, 22'h000102, 8'd0, 3'b000, 2'b01, 64'h1, ok, resp, id_o, ww, bw);
        wbuf[0] = 32'h0000_0055;
        axi_write(4'h1, 22'h000103, 8'd0, 3'b000, 2'b01, 64'h0, ok, resp, id_o, ww, bw);
        axi_read(4'h1, 22'h000100, 8'd0, 3'b010, 2'b01, 1'b0, ok, fw);
        total++;
        if (rdat_a[0] !== 32'h11AA_3344) begin
            bad++;
            $display("FAIL sb_word got=%h want=11aa3344", rdat_a[0]);
        end
        axi_read(4'h1, 22'h000102, 8'd0, 3'b000, 2'b01, 1'b0, ok, fw);
        total++;
        if (rdat_a[0] !== 32'h0000_00AA) begin
            bad++;
            $display("FAIL lb got=%h want=000000aa", rdat_a[0]);
        end
        axi_read(4'h1, 22'h000100, 8'd3, 3'b000, 2'b01, 1'b0, ok, fw);
        total++;
        if ({rdat_a[0][7:0], rdat_a[1][7:0], rdat_a[2][7:0], rdat_a[3][7:0]} !== 32'h4433_AA11
            || rdat_a[1][31:8] !== 24'h0) begin
            bad++;
            $display("FAIL lb_burst got=%h %h %h %h want=44 33 aa 11", rdat_a[0], rdat_a[1], rdat_a[2], rdat_a[3]);
        end
        wbuf[0] = 32'hFFFF_FFFF;
        axi_write(4'h1, 22'h000100, 8'd0, 3'b010, 2'b01, 64'h3, ok, resp, id_o, ww, bw);
        axi_read(4'h1, 22'h000100, 8'd0, 3'b111, 2'b01, 1'b0, ok, fw);
        total++;
        if (rdat_a[0] !== 32'h11AA_FFFF) begin
            bad++;
            $display("FAIL partial_strb got=%h want=11aaffff", rdat_a[0]);
        end
    endtask

    task automatic test_incr_burst;
        logic ok; logic [1:0] resp; logic [3:0] id_o; int ww, bw, fw;
        for (int b = 0; b < 4; b++) wbuf[b] = 32'(b + 1);
        axi_write(4'h2, 22'h000200, 8'd3, 3'b010, 2'b01, 64'hF, ok, resp, id_o, ww, bw);
        total++;
        if (!ok || resp !== 2'b00) begin
            bad++;
            $display("FAIL burst_wr got=ok%0d/%b want=ok1/00", ok, resp);
        end
        axi_read(4'h2, 22'h000200, 8'd3, 3'b010, 2'b01, 1'b1, ok, fw);
        for (int b = 0; b < 4; b++) begin
            total++;
            if (rdat_a[b] !== 32'(b + 1) || rdat_b[b] !== 32'(b + 1)) begin
                bad++;
                $display("FAIL burst_rd_beat%0d got=%h/%h want=%h", b, rdat_a[b], rdat_b[b], 32'(b + 1));
            end
            total++;
            if (rlast_b[b] !== (b == 3)) begin
                bad++;
                $display("FAIL burst_rlast%0d got=%b want=%b", b, rlast_b[b], (b == 3));
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL burst_rd_timeout got=0 want=1");
        end
        axi_read(4'h2, 22'h000204, 8'd1, 3'b010, 2'b00, 1'b0, ok, fw);
        total++;
        if (rdat_a[0] !== 32'h2 || rdat_a[1] !== 32'h2) begin
            bad++;
            $display("FAIL fixed_rd got=%h %h want=2 2", rdat_a[0], rdat_a[1]);
        end
    endtask

    task automatic test_out_of_range;
        logic ok; logic [1:0] resp; logic [3:0] id_o; int ww, bw, fw;
        wbuf[0] = 32'hCAFE_F00D;
        axi_write(4'h0, 22'h000000, 8'd0, 3'b010, 2'b01, 64'hF, ok, resp, id_o, ww, bw);
        wbuf[0] = 32'h1234_5678;
        axi_write(4'h7, 22'h001000, 8'd0, 3'b010, 2'b01, 64'hF, ok, resp, id_o, ww, bw);
        total++;
        if (resp !== 2'b10 || id_o !== 4'h7) begin
            bad++;
            $display("FAIL oor_bresp got=%b/%h want=10/7", resp, id_o);
        end
        axi_read(4'h0, 22'h000000, 8'd0, 3'b010, 2'b01, 1'b0, ok, fw);
        total++;
        if (rdat_a[0] !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL oor_no_alias got=%h want=cafef00d", rdat_a[0]);
        end
        axi_read(4'h0, 22'h001000, 8'd0, 3'b010, 2'b01, 1'b0, ok, fw);
        total++;
        if (rdat_a[0] !== 32'h0 || rresp_b[0] !== 2'b10 || rlast_b[0] !== 1'b1) begin
            bad++;
            $display("FAIL oor_rd got=%h/%b/%b want=0/10/1", rdat_a[0], rresp_b[0], rlast_b[0]);
        end
        wbuf[0] = 32'hA5A5_A5A5;
        wbuf[1] = 32'h5A5A_5A5A;
        axi_write(4'h6, 22'h000FFC, 8'd1, 3'b010, 2'b01, 64'hF, ok, resp, id_o, ww, bw);
        total++;
        if (resp !== 2'b10) begin
            bad++;
            $display("FAIL cross_bresp got=%b want=10", resp);
        end
        axi_read(4'h0, 22'h000FFC, 8'd1, 3'b010, 2'b01, 1'b0, ok, fw);
        total++;
        if (rdat_a[0] !== 32'hA5A5_A5A5 || rresp_b[0] !== 2'b00 || rdat_a[1] !== 32'h0 || rresp_b[1] !== 2'b10) begin
            bad++;
            $display("FAIL cross_rd got=%h/%b %h/%b want=a5a5a5a5/00 0/10", rdat_a[0], rresp_b[0], rdat_a[1], rresp_b[1]);
        end
    endtask

    task automatic test_conflict;
        logic ok; logic [1:0] resp; logic [3:0] id_o; int ww, bw;
        wbuf[0] = 32'h9;
        axi_write(4'h0, 22'h000300, 8'd0, 3'b010, 2'b01, 64'hF, ok, resp, id_o, ww, bw);
        awid = 4'h4; awaddr = 22'h000300; awlen = 8'd0; awsize = 3'b010; awburst = 2'b01; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        arid = 4'h8; araddr = 22'h000300; arlen = 8'd0; arsize = 3'b010; arburst = 2'b01; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        wdata = 32'h5; wstrb = 64'hF; wlast = 1'b1; wvalid = 1'b1; rready = 1'b1;
        step();
        wvalid = 1'b0; wlast = 1'b0;
        total++;
        if (rvalid !== 1'b0 || bvalid !== 1'b1) begin
            bad++;
            $display("FAIL conflict_stall got=rv%b/bv%b want=rv0/bv1", rvalid, bvalid);
        end
        bready = 1'b1;
        step();
        total++;
        if (rvalid !== 1'b1 || rdata !== 32'h5 || rresp !== 2'b00) begin
            bad++;
            $display("FAIL conflict_data got=%b/%h/%b want=1/5/00", rvalid, rdata, rresp);
        end
        step();
        rready = 1'b0; bready = 1'b0;
        total++;
        if (awready !== 1'b1 || arready !== 1'b1) begin
            bad++;
            $display("FAIL conflict_idle got=%b%b want=11", awready, arready);
        end
    endtask

    task automatic test_backpressure_reset;
        logic ok; int fw;
        awid = 4'h9; awaddr = 22'h000304; awlen = 8'd0; awsize = 3'b010; awburst = 2'b01; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        wdata = 32'h77; wstrb = 64'hF; wlast = 1'b1; wvalid = 1'b1; bready = 1'b0;
        step();
        wvalid = 1'b0; wlast = 1'b0;
        for (int c = 0; c < 10; c++) begin
            total++;
            if ({bvalid, awready} !== 2'b10) begin
                bad++;
                $display("FAIL b_hold_cycle%0d got=%b want=10", c, {bvalid, awready});
            end
            step();
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        arid = 4'hA; araddr = 22'h000200; arlen = 8'd3; arsize = 3'b010; arburst = 2'b01; arvalid = 1'b1;
        step();
        arvalid = 1'b0; rready = 1'b1;
        step();
        step();
        step();
        total++;
        if (rvalid !== 1'b1 || rdata !== 32'h2) begin
            bad++;
            $display("FAIL midburst_beat1 got=%b/%h want=1/2", rvalid, rdata);
        end
        rstn = 1'b0;
        step();
        total++;
        if ({rvalid, arready, awready, rlast} !== 4'b0110) begin
            bad++;
            $display("FAIL midburst_reset got=%b want=0110", {rvalid, arready, awready, rlast});
        end
        rstn = 1'b1; rready = 1'b0;
        step();
        axi_read(4'h0, 22'h000304, 8'd0, 3'b010, 2'b01, 1'b0, ok, fw);
        total++;
        if (rdat_a[0] !== 32'h77) begin
            bad++;
            $display("FAIL mem_kept got=%h want=77", rdat_a[0]);
        end
    endtask

    initial begin
        rstn = 1'b0;
        awid = 4'h0; awaddr = 22'h0; awlen = 8'h0; awsize = 3'b010; awburst = 2'b01; awvalid = 1'b0;
        wdata = 32'h0; wstrb = 64'h0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = 4'h0; araddr = 22'h0; arlen = 8'h0; arsize = 3'b010; arburst = 2'b01; arvalid = 1'b0;
        rready = 1'b0;
        step();
        test_reset();
        test_word_round_trip();
        test_byte_ops();
        test_incr_burst();
        test_out_of_range();
        test_conflict();
        test_backpressure_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
